seq_det_sched: RTL and testbench

- Round-robin scheduler that shares one external serial sequence detector (1100/1000, non-resetting, Mealy, active-low Z_BAR) among 4 requesters.
- Each grant runs one frame:
  - clears the detector's history with a one-cycle reset pulse;
  - shifts the requester's 8-bit word MSB-first into the detector's X input;
  - counts cycles with Z_BAR low;
  - returns the count with a one-cycle ack.
- Sits between the requester ports and the detector instance.

---
 rtl/seq_det_sched.sv | 142 ++++++++++++++
 tb/tb_seq_det_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial 1100/1000 detector among 4 requesters.
// Define SEQ_DET_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module seq_det_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*FRAME_BITS-1:0]   req_data,
  output logic [NREQ-1:0]              ack,
  output logic [CNT_W-1:0]             result,
  output logic                         busy,
  output logic                         det_x,
  output logic                         det_rst_n,
  input  logic                         det_z_bar
);

  localparam int unsigned PTR_W  = 2;
  localparam int unsigned BCNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_gnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [BCNT_W-1:0]     r_bit_cnt;
  logic [CNT_W-1:0]      r_hit_cnt;
  logic [NREQ-1:0]       r_ack;
  logic [CNT_W-1:0]      r_result;
  logic                  r_busy;
  logic                  r_det_rst_n;

  logic [FRAME_BITS-1:0] w_words [NREQ];
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_pick;
  logic                  w_found;
  logic [CNT_W-1:0]      w_hit_nxt;

  // Per-requester byte view of the flat data bus
  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign w_words[g] = req_data[g*FRAME_BITS +: FRAME_BITS];
  end

  // Scan from rr_ptr upward; descending loop so the smallest offset wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = PTR_W'(r_rr_ptr + PTR_W'(i));
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Saturating hit count including the current SHIFT cycle
  always_comb begin
    w_hit_nxt = r_hit_cnt;
    if (!det_z_bar && (r_hit_cnt != CNT_MAX)) begin
      w_hit_nxt = r_hit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_hit_cnt   <= '0;
      r_ack       <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_det_rst_n <= 1'b0;
    end else begin
      r_ack    <= '0;
      r_result <= '0;
      case (r_state)
        ST_IDLE: begin
          r_det_rst_n <= 1'b1;
          if (w_found) begin
            r_gnt       <= w_pick;
            r_shift     <= w_words[w_pick];
            r_hit_cnt   <= '0;
            r_det_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_det_rst_n <= 1'b1;
          r_bit_cnt   <= '0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_hit_cnt <= w_hit_nxt;
          r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            // Ack/result are loaded here so they are visible throughout DONE
            r_ack    <= NREQ'(1) << r_gnt;
            r_result <= w_hit_nxt;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
          r_rr_ptr <= '0;
`else
          r_rr_ptr <= r_gnt + PTR_W'(1);
`endif
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Serial bit goes straight from the shift register so the detector sees it this cycle
  assign det_x     = (r_state == ST_SHIFT) && r_shift[FRAME_BITS-1];
  assign det_rst_n = r_det_rst_n;
  assign ack       = r_ack;
  assign result    = r_result;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with a behavioural 1100/1000 overlapping detector.
// A second instance with CNT_W=1 checks counter saturation.
module tb_seq_det_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;

  logic [3:0]  ack;
  logic [3:0]  result;
  logic        busy;
  logic        det_x;
  logic        det_rst_n;
  logic        det_z_bar;

  logic [3:0]  ack_s;
  logic [0:0]  result_s;
  logic        busy_s;
  logic        det_x_s;
  logic        det_rst_n_s;
  logic        det_z_bar_s;

  logic [2:0]  hist;
  logic [2:0]  hist_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_det_sched u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .result(result), .busy(busy), .det_x(det_x),
    .det_rst_n(det_rst_n), .det_z_bar(det_z_bar)
  );

  seq_det_sched #(.CNT_W(1)) u_sat (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack_s), .result(result_s), .busy(busy_s), .det_x(det_x_s),
    .det_rst_n(det_rst_n_s), .det_z_bar(det_z_bar_s)
  );

  // Mealy detector: Z_BAR low when the last three bits plus X form 1100 or 1000
  always_ff @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) hist <= 3'b000;
    else            hist <= {hist[1:0], det_x};
  end
  assign det_z_bar = !(({hist, det_x} == 4'b1100) || ({hist, det_x} == 4'b1000));

  always_ff @(posedge clk or negedge det_rst_n_s) begin
    if (!det_rst_n_s) hist_s <= 3'b000;
    else              hist_s <= {hist_s[1:0], det_x_s};
  end
  assign det_z_bar_s = !(({hist_s, det_x_s} == 4'b1100) || ({hist_s, det_x_s} == 4'b1000));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((ack == 4'b0000) && (n < limit));
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b0000; req_data = 32'h0;
    #12;
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    n_vec++; if (result !== 4'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (det_x !== 1'b0) begin n_err++; $display("FAIL reset_det_x got=%b exp=0", det_x); end
    n_vec++; if (det_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_det_rst_n got=%b exp=0", det_rst_n); end
    tick();
    reset = 1'b1;
    tick();
    n_vec++; if (det_rst_n !== 1'b1) begin n_err++; $display("FAIL idle_det_rst_n got=%b exp=1", det_rst_n); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int n;
    req_data = 32'h000000C0;
    req = 4'b0001;
    tick();
    n_vec++; if (det_rst_n !== 1'b0) begin n_err++; $display("FAIL clear_det_rst_n got=%b exp=0", det_rst_n); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy got=%b exp=1", busy); end
    tick();
    n_vec++; if (det_rst_n !== 1'b1) begin n_err++; $display("FAIL shift_det_rst_n got=%b exp=1", det_rst_n); end
    n_vec++; if (det_x !== 1'b1) begin n_err++; $display("FAIL shift_det_x0 got=%b exp=1", det_x); end
    wait_ack(30, n);
    n_vec++; if (n !== 8) begin n_err++; $display("FAIL single_latency got=%0d exp=8 (after 2 cycles)", n); end
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL single_ack got=%b exp=0001", ack); end
    n_vec++; if (result !== 4'd2) begin n_err++; $display("FAIL single_result got=%0d exp=2", result); end
    n_vec++; if (result_s !== 1'b1) begin n_err++; $display("FAIL sat_result got=%0d exp=1", result_s); end
    n_vec++; if (ack_s !== 4'b0001) begin n_err++; $display("FAIL sat_ack got=%b exp=0001", ack_s); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL done_busy got=%b exp=1", busy); end
    req = 4'b0000;
    tick();
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL ack_pulse got=%b exp=0000", ack); end
    n_vec++; if (result !== 4'd0) begin n_err++; $display("FAIL result_clear got=%0d exp=0", result); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_drop got=%b exp=0", busy); end
  endtask

  task automatic test_data_patterns();
    logic [7:0] data  [3];
    logic [3:0] exp_r [3];
    logic       exp_s [3];
    int n;
    data[0] = 8'h88; exp_r[0] = 4'd2; exp_s[0] = 1'b1;
    data[1] = 8'hFF; exp_r[1] = 4'd0; exp_s[1] = 1'b0;
    data[2] = 8'h00; exp_r[2] = 4'd0; exp_s[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_data = {8'h00, data[k], 16'h0000};
      req = 4'b0100;
      wait_ack(30, n);
      n_vec++; if (n !== 10) begin n_err++; $display("FAIL pat%0d_latency got=%0d exp=10", k, n); end
      n_vec++; if (ack !== 4'b0100) begin n_err++; $display("FAIL pat%0d_ack got=%b exp=0100", k, ack); end
      n_vec++; if (result !== exp_r[k]) begin n_err++; $display("FAIL pat%0d_result got=%0d exp=%0d", k, result, exp_r[k]); end
      n_vec++; if (result_s !== exp_s[k]) begin n_err++; $display("FAIL pat%0d_sat got=%0d exp=%0d", k, result_s, exp_s[k]); end
      req = 4'b0000;
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a [5];
    logic [3:0] exp_r [5];
    int n;
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++) begin exp_a[k] = 4'b0001; exp_r[k] = 4'd2; end
`else
    exp_a[0] = 4'b0001; exp_r[0] = 4'd2;
    exp_a[1] = 4'b0010; exp_r[1] = 4'd2;
    exp_a[2] = 4'b0100; exp_r[2] = 4'd0;
    exp_a[3] = 4'b1000; exp_r[3] = 4'd1;
    exp_a[4] = 4'b0001; exp_r[4] = 4'd2;
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_data = 32'h0CFF88C0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(30, n);
      n_vec++; if (n !== ((k == 0) ? 10 : 11)) begin n_err++; $display("FAIL rr%0d_spacing got=%0d exp=%0d", k, n, (k == 0) ? 10 : 11); end
      n_vec++; if (ack !== exp_a[k]) begin n_err++; $display("FAIL rr%0d_ack got=%b exp=%b", k, ack, exp_a[k]); end
      n_vec++; if (result !== exp_r[k]) begin n_err++; $display("FAIL rr%0d_result got=%0d exp=%0d", k, result, exp_r[k]); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_clear_history();
    logic [7:0] data  [4];
    logic [3:0] exp_r [4];
    int n;
    data[0] = 8'hC8; exp_r[0] = 4'd2;
    data[1] = 8'h00; exp_r[1] = 4'd0;
    data[2] = 8'h06; exp_r[2] = 4'd0;
    data[3] = 8'h00; exp_r[3] = 4'd0;
    for (int k = 0; k < 4; k++) begin
      req_data = {24'h000000, data[k]};
      req = 4'b0001;
      wait_ack(30, n);
      n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL hist%0d_ack got=%b exp=0001", k, ack); end
      n_vec++; if (result !== exp_r[k]) begin n_err++; $display("FAIL hist%0d_result got=%0d exp=%0d", k, result, exp_r[k]); end
      req = 4'b0000;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int n;
    req_data = 32'h000000C0;
    req = 4'b0001;
    for (int k = 0; k < 6; k++) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL mid_ack got=%b exp=0000", ack); end
    n_vec++; if (det_rst_n !== 1'b0) begin n_err++; $display("FAIL mid_det_rst_n got=%b exp=0", det_rst_n); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b exp=0", busy); end
    tick();
    tick();
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL mid_ack_held got=%b exp=0000", ack); end
    reset = 1'b1;
    wait_ack(30, n);
    n_vec++; if (n !== 10) begin n_err++; $display("FAIL post_latency got=%0d exp=10", n); end
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL post_ack got=%b exp=0001", ack); end
    n_vec++; if (result !== 4'd2) begin n_err++; $display("FAIL post_result got=%0d exp=2", result); end
    req = 4'b0000;
    tick();
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL post_ack_pulse got=%b exp=0000", ack); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_data_patterns();
    test_round_robin();
    test_clear_history();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
